// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: drains wide words from the synchronous FIFO read port
// and emits them as NUM_BEATS narrow beats on a valid/ready stream.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | no word held, outputs quiet, pops as soon as the FIFO has data
// ACTIVE | word_q held, beat beat_cnt_q presented on data_o
//
// A new word is popped in the same cycle the final beat of the held word is
// accepted, so back-to-back words stream at one beat per cycle.
module fifo_rd_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int NUM_BEATS = IN_WIDTH / OUT_WIDTH,
  parameter int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_chk
    $error("fifo_rd_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  if (NUM_BEATS != IN_WIDTH / OUT_WIDTH) begin : g_beats_chk
    $error("fifo_rd_serializer: NUM_BEATS is derived and must not be overridden");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IN_WIDTH-1:0]  word_q;
  logic                 active;
  logic                 last_beat;
  logic                 beat_acc;
  logic                 load;
  logic [CNT_W-1:0]     sel;

  assign active    = (state_q == ACTIVE);
  assign last_beat = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
  assign beat_acc  = active & ready_i;

  // Pop when nothing is held, or when the held word's final beat leaves this cycle.
  assign load = ~flush_i & ~fifo_empty_i & (~active | (beat_acc & last_beat));

  assign fifo_pop_o = load;
  assign valid_o    = active;
  assign last_o     = active & last_beat;
  assign busy_o     = active;

  // Next-state and beat counter; flush overrides load and beat acceptance.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (flush_i) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (load) begin
      state_d    = ACTIVE;
      beat_cnt_d = '0;
    end else if (beat_acc) begin
      if (last_beat) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and beat counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Word holding register; only written on a pop, left as-is on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= fifo_data_i;
    end
  end

  // Beat select; output forced to zero while idle.
  always_comb begin
    sel    = MSB_FIRST ? (CNT_W'(NUM_BEATS - 1) - beat_cnt_q) : beat_cnt_q;
    data_o = '0;
    if (active) begin
      for (int i = 0; i < NUM_BEATS; i++) begin
        if (sel == CNT_W'(i)) begin
          data_o = word_q[i*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  a_pop_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_pop_o |-> !fifo_empty_i);

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> ($stable(data_o) && valid_o));

endmodule
